// File: rtl/pipelined_carry_skip_adder_pkg.sv
// Purpose : shared geometry helpers for the pipelined carry-skip adder.
// Latency : n/a (compile-time constants only).
// Backpr. : n/a.
//
// The adder is cut into NUM_BLOCKS = WIDTH/BLOCK skip blocks. Each of the
// STAGES register slices owns BPS = NUM_BLOCKS/STAGES consecutive blocks.
package pipelined_carry_skip_adder_pkg;

  // Number of carry-skip blocks across the whole operand.
  function automatic int calc_num_blocks(input int width, input int block);
    return width / block;
  endfunction

  // Blocks evaluated by each pipeline stage.
  function automatic int calc_bps(input int width, input int block, input int stages);
    return (width / block) / stages;
  endfunction

  // Bits of result produced by each pipeline stage.
  function automatic int calc_seg_bits(input int width, input int block, input int stages);
    return ((width / block) / stages) * block;
  endfunction

  // Geometry is legal when blocks tile the operand exactly and the blocks
  // split evenly over the stages.
  function automatic bit geometry_ok(input int width, input int block, input int stages);
    return (width > 0) && (block > 0) && (stages > 0) &&
           ((width % block) == 0) &&
           (((width / block) % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_carry_skip_adder_csa_block.sv
// Purpose : one BLOCK-bit ripple adder with a propagate-skip carry-out mux.
// Latency : purely combinational.
// Backpr. : none; evaluated every cycle by the owning pipeline stage.
//
// Ports:
//   a, b   in  BLOCK  operand slices
//   ci     in  1      block carry-in
//   s      out BLOCK  slice sum
//   co     out 1      block carry-out (skip path when every bit propagates)
//   c_msb  out 1      carry into the top bit of the slice (signed overflow)
module csa_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin : p_ripple
    logic rc;
    rc    = ci;
    s     = '0;
    c_msb = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      if (i == BLOCK - 1) begin
        c_msb = rc;
      end
      s[i] = p[i] ^ rc;
      rc   = g[i] | (p[i] & rc);
    end
    // When all bits propagate the ripple result equals ci anyway; taking ci
    // directly shortens the carry path into the next block.
    co = (&p) ? ci : rc;
  end

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Purpose : pipelined a+b+cin adder built from carry-skip blocks split over STAGES slices.
// Latency : STAGES cycles from input transfer to out_valid when unstalled; 1 result/cycle.
// Backpr. : per-stage valid with bubble collapse; in_ready falls only when every stage is full.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake for a, b, cin
//   a, b (WIDTH), cin        operands
//   out_valid/out_ready      result handshake for sum, cout, ovf
//   sum (WIDTH), cout, ovf   (a+b+cin) mod 2^WIDTH, carry out, signed overflow
//
// Each stage k adds its own SEG-bit slice using the carry registered by the
// previous stage, then registers: the sum bits produced so far, its carry-out
// and the operand bits still to be added by later stages.
module pipelined_carry_skip_adder
  import pipelined_carry_skip_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM_BLOCKS = calc_num_blocks(WIDTH, BLOCK);
  localparam int BPS        = calc_bps(WIDTH, BLOCK, STAGES);
  localparam int SEG        = calc_seg_bits(WIDTH, BLOCK, STAGES);

  if (!geometry_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_geometry
    $error("pipelined_carry_skip_adder: WIDTH must be a multiple of BLOCK and WIDTH/BLOCK (%0d) a multiple of STAGES",
           NUM_BLOCKS);
  end

  // ---------------------------------------------------------------------
  // Handshake: one valid bit per stage, bubbles collapse.
  // ---------------------------------------------------------------------
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] load;    // stage k captures new contents this cycle
  logic [STAGES-1:0] st_vld;  // valid bit presented to stage k

  // A stage can load when it is empty or its contents leave this cycle; the
  // readiness ripples from out_ready back towards the input.
  always_comb begin : p_load
    logic rdy_down;
    load     = '0;
    rdy_down = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k]  = ~vld_q[k] | rdy_down;
      rdy_down = load[k];
    end
  end

  assign in_ready = ~rst & load[0];

  always_comb begin : p_vld
    st_vld    = '0;
    st_vld[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) begin
      st_vld[k] = vld_q[k-1];
    end
    vld_d = vld_q;
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        vld_d[k] = st_vld[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath slices.
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int IN_W   = WIDTH - k * SEG;  // operand bits arriving at this stage
    localparam int REM_W  = IN_W - SEG;       // operand bits left for later stages
    localparam int DONE_W = (k + 1) * SEG;    // sum bits known after this stage

    logic [IN_W-1:0]   op_a;
    logic [IN_W-1:0]   op_b;
    logic              op_ci;
    logic [SEG-1:0]    seg_sum;
    logic              seg_co;
    logic [DONE_W-1:0] sum_new;
    logic [DONE_W-1:0] sum_d;
    logic [DONE_W-1:0] sum_q;
    logic              carry_d;
    logic              carry_q;
    logic              take;

    // Data only moves on a real transfer, so outputs hold through bubbles.
    assign take = load[k] & st_vld[k];

    if (k == 0) begin : g_src
      assign op_a    = a;
      assign op_b    = b;
      assign op_ci   = cin;
      assign sum_new = seg_sum;
    end else begin : g_src
      assign op_a    = g_stg[k-1].g_rem.a_rem_q;
      assign op_b    = g_stg[k-1].g_rem.b_rem_q;
      assign op_ci   = g_stg[k-1].carry_q;
      assign sum_new = {seg_sum, g_stg[k-1].sum_q};
    end

    for (genvar i = 0; i < BPS; i++) begin : g_blk
      logic [BLOCK-1:0] s;
      logic             ci;
      logic             co;
      logic             c_msb;

      if (i == 0) begin : g_ci
        assign ci = op_ci;
      end else begin : g_ci
        assign ci = g_blk[i-1].co;
      end

      csa_block #(
        .BLOCK (BLOCK)
      ) u_csa (
        .a     (op_a[i*BLOCK +: BLOCK]),
        .b     (op_b[i*BLOCK +: BLOCK]),
        .ci    (ci),
        .s     (s),
        .co    (co),
        .c_msb (c_msb)
      );

      assign seg_sum[i*BLOCK +: BLOCK] = s;

      // Only the most significant block of the whole word feeds ovf.
      if (!((k == STAGES - 1) && (i == BPS - 1))) begin : g_msb_unused
        logic c_msb_unused;
        assign c_msb_unused = c_msb;
      end
    end

    assign seg_co = g_blk[BPS-1].co;

    always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      if (take) begin
        sum_d   = sum_new;
        carry_d = seg_co;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end

    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] a_rem_d;
      logic [REM_W-1:0] a_rem_q;
      logic [REM_W-1:0] b_rem_d;
      logic [REM_W-1:0] b_rem_q;

      always_comb begin
        a_rem_d = a_rem_q;
        b_rem_d = b_rem_q;
        if (take) begin
          a_rem_d = op_a[IN_W-1:SEG];
          b_rem_d = op_b[IN_W-1:SEG];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_comb begin
        ovf_d = ovf_q;
        if (take) begin
          ovf_d = g_blk[BPS-1].c_msb ^ seg_co;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = g_stg[STAGES-1].sum_q;
  assign cout      = g_stg[STAGES-1].carry_q;
  assign ovf       = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Purpose : self-checking bench for pipelined_carry_skip_adder (32/4/2).
// Latency : checks STAGES-cycle latency on isolated transfers.
// Backpr. : drives stalls, back-to-back streams, mid-flight reset and random valid/ready.
module tb_pipelined_carry_skip_adder;

  localparam int WIDTH  = 32;
  localparam int BLOCK  = 4;
  localparam int STAGES = 2;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             cin       = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  always #5 clk = ~clk;

  pipelined_carry_skip_adder #(
    .WIDTH  (WIDTH),
    .BLOCK  (BLOCK),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] sum;
  } res_t;

  // Golden arithmetic: wide add, overflow from operand/result signs.
  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    logic [WIDTH:0] full;
    res_t           r;
    full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and monitor state.
  res_t q[$];
  int   cyc          = 0;
  bit   stall_v      = 1'b0;
  res_t held;
  bit   track_en     = 1'b0;
  int   n_out        = 0;
  int   gaps         = 0;
  int   last_out_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Checks every cycle at the falling edge, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
      q.delete();
      stall_v = 1'b0;
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, !((q.size() >= STAGES) && !out_ready)});
      if (q.size() == 0) chk("no_phantom_valid", {63'd0, out_valid}, 64'd0);
      if (stall_v && out_valid) chk("stall_hold", {30'd0, cout, ovf, sum}, {30'd0, held});
      if (out_valid && out_ready) begin
        if (q.size() != 0) chk("result", {30'd0, cout, ovf, sum}, {30'd0, q.pop_front()});
        if (track_en) begin
          if ((last_out_cyc >= 0) && (cyc != last_out_cyc + 1)) gaps++;
          last_out_cyc = cyc;
          n_out++;
        end
      end
      stall_v = out_valid && !out_ready;
      held    = {cout, ovf, sum};
      if (in_valid && in_ready) q.push_back(model(a, b, cin));
    end
  end

  // Isolated transfer with literal expectation and latency measurement.
  task automatic direct(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                        input res_t exp, input string name);
    int lat;
    @(posedge clk); #1;
    a = x; b = y; cin = c; in_valid = 1'b1;
    chk({name, "_model"}, {30'd0, model(x, y, c)}, {30'd0, exp});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, STAGES);
    chk({name, "_result"}, {30'd0, cout, ovf, sum}, {30'd0, exp});
  endtask

  task automatic drain(input string name);
    int w;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (q.size() != 0 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    int accepts;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_sum", {32'd0, sum}, 64'd0);
    chk("reset_cout_ovf", {62'd0, cout, ovf}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;

    // Directed vectors with hand-computed results.
    direct(32'h8ED56AC8, 32'h7DA662A9, 1'b0, '{cout: 1'b1, ovf: 1'b0, sum: 32'h0C7BCD71}, "t1");
    direct(32'h2EEAAAC8, 32'h56A67559, 1'b0, '{cout: 1'b0, ovf: 1'b1, sum: 32'h85912021}, "t2");
    direct(32'hFFFFFFFF, 32'h00000000, 1'b1, '{cout: 1'b1, ovf: 1'b0, sum: 32'h00000000}, "t3_skip");
    direct(32'h7FFFFFFF, 32'h00000001, 1'b0, '{cout: 1'b0, ovf: 1'b1, sum: 32'h80000000}, "t3_ovf");
    direct(32'h80000000, 32'h80000000, 1'b0, '{cout: 1'b1, ovf: 1'b1, sum: 32'h00000000}, "neg_ovf");

    // Ten back-to-back transfers.
    @(posedge clk); #1;
    n_out = 0; gaps = 0; last_out_cyc = -1; track_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a   = (32'h01010101 * i) ^ ((i % 2) ? 32'h80000000 : 32'h0);
      b   = 32'hFEDCBA98 >> i;
      cin = i[0];
      in_valid = 1'b1;
      #1;
      chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (STAGES + 3) @(posedge clk);
    #1;
    track_en = 1'b0;
    chk("b2b_count", n_out, 10);
    chk("b2b_gaps", gaps, 0);

    // Stall: stream with out_ready low for five cycles.
    out_ready = 1'b0;
    accepts   = 0;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; cin = i[0];
      in_valid = 1'b1;
      #1;
      if (in_ready) accepts++;
      @(posedge clk); #1;
    end
    chk("stall_accepts", accepts, STAGES);
    chk("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
    drain("stall_drain_empty");
    repeat (3) @(posedge clk);
    #1;
    chk("stall_no_extra_output", {63'd0, out_valid}, 64'd0);

    // Reset with the pipeline full.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) begin
      a = 32'hA5A50000 + i; b = 32'h5A5AFFFF; cin = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("full_before_reset", {63'd0, out_valid}, 64'd1);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
    chk("rst_in_ready_high", {63'd0, in_ready}, 64'd1);
    n_out = 0; last_out_cyc = -1; track_en = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    track_en = 1'b0;
    chk("rst_no_stale", n_out, 0);

    // Random valid/ready traffic with corner operands mixed in.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'hFFFFFFFF;
        1: a = 32'h7FFFFFFF;
        2: a = 32'h80000000;
        default: a = $urandom;
      endcase
      b         = ($urandom_range(0, 3) == 0) ? ~a : $urandom;
      cin       = $urandom_range(0, 1);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain("random_drain_empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1, "timeout");
  end

endmodule
